pipe_addsub: RTL and testbench

//   Parametrised, pipelined adder/subtractor; sequential successor to the combinational rca.

---
 rtl/pipe_addsub.sv | 98 +++++++++
 tb/tb_pipe_addsub.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor with a valid/ready handshake.
//   The WIDTH-bit carry chain is cut into STAGES slices of WIDTH/STAGES bits.
//   Slice k is added in the cycle before stage k registers it. The upper operand
//   bits travel forward (skew) and the finished lower sum bits travel forward
//   (deskew), so the last stage holds a complete, aligned result.
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid, in_ready   operand beat handshake
//   a, b, sub            operands; sub=1 selects a-b
//   out_valid, out_ready result beat handshake
//   sum, cout, ovf       result, carry out of the MSB (sub: 1 = no borrow),
//                        signed overflow
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SD = (STAGES < 1) ? 1 : STAGES;
    localparam int S  = WIDTH / SD;

    if ((STAGES < 1) || ((WIDTH % SD) != 0)) begin : g_bad_param
        $error("pipe_addsub: STAGES must be >= 1 and divide WIDTH");
    end

    // Whole pipeline moves together; a bubble still occupies its slot.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SD; k++) begin : g_stg
        // LO: first bit of the slice added ahead of this stage.
        // UP: lowest operand bit still needed downstream; the last stage only
        //     keeps the operand MSBs for the overflow check.
        localparam int LO = k * S;
        localparam int UP = (k == SD - 1) ? WIDTH - 1 : (k + 1) * S;

        logic [WIDTH-1:LO]  a_i, bx_i;
        logic               c_i, v_i;
        logic [S:0]         t;
        logic [LO+S-1:0]    s_n;
        logic [WIDTH-1:UP]  a_q, bx_q;
        logic [LO+S-1:0]    s_q;
        logic               c_q, v_q;

        assign t = {1'b0, a_i[LO+S-1:LO]} + {1'b0, bx_i[LO+S-1:LO]} + {{S{1'b0}}, c_i};

        if (k == 0) begin : g_first
            assign a_i  = a;
            assign bx_i = sub ? ~b : b;
            assign c_i  = sub;
            assign v_i  = in_valid;
            assign s_n  = t[S-1:0];
        end else begin : g_next
            assign a_i  = g_stg[k-1].a_q;
            assign bx_i = g_stg[k-1].bx_q;
            assign c_i  = g_stg[k-1].c_q;
            assign v_i  = g_stg[k-1].v_q;
            assign s_n  = {t[S-1:0], g_stg[k-1].s_q};
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                a_q  <= '0;
                bx_q <= '0;
                s_q  <= '0;
                c_q  <= 1'b0;
            end else if (adv) begin
                v_q  <= v_i;
                a_q  <= a_i[WIDTH-1:UP];
                bx_q <= bx_i[WIDTH-1:UP];
                s_q  <= s_n;
                c_q  <= t[S];
            end
        end
    end

    assign out_valid = g_stg[SD-1].v_q;
    assign sum       = g_stg[SD-1].s_q;
    assign cout      = g_stg[SD-1].c_q;
    // Built only from last-stage registers, so it changes only on adv and is
    // 0 after reset (all MSBs equal zero).
    assign ovf = (g_stg[SD-1].a_q[WIDTH-1] == g_stg[SD-1].bx_q[WIDTH-1]) &&
                 (g_stg[SD-1].s_q[WIDTH-1] != g_stg[SD-1].a_q[WIDTH-1]);

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub (WIDTH=16, STAGES=4).
module tb_pipe_addsub;
    localparam int W   = 16;
    localparam int STG = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf;

    pipe_addsub #(.WIDTH(W), .STAGES(STG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   lat_mode  = 1'b1;
    bit   burst_chk = 1'b0;
    bit   bub_chk   = 1'b0;
    bit   rand_rdy  = 1'b0;
    bit   acc_hist [0:8191];

    // Reference: plain integer arithmetic on the unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            r      = ux + uy;
            e.cout = (r >= 65536);
            sr     = sx + sy;
        end else begin
            r      = ux - uy + 65536;
            e.cout = (ux >= uy);
            sr     = sx - sy;
        end
        e.sum     = W'(r % 65536);
        e.ovf     = (sr > 32767) || (sr < -32768);
        e.cyc     = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor/scoreboard: decisions are taken at the negedge before the edge
    // that performs the accept or delivery.
    initial begin : monitor
        exp_t e;
        bit   stalled;
        bit   have_prev;
        int   prev_del;
        stalled   = 1'b0;
        have_prev = 1'b0;
        prev_del  = 0;
        forever begin
            @(negedge clk);
            if (!burst_chk) have_prev = 1'b0;
            if (!rst_n) begin
                sb.delete();
                stalled = 1'b0;
                acc_hist[cyc % 8192] = 1'b0;
            end else begin
                if (bub_chk && cyc >= STG)
                    check("bubble_pattern", int'(out_valid), int'(acc_hist[(cyc - STG) % 8192]));
                if (out_valid && !out_ready) begin
                    check("in_ready_stall", int'(in_ready), 0);
                    stalled = 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("result", int'({sum, cout, ovf}), int'({e.sum, e.cout, e.ovf}));
                        if (e.chk_lat) check("latency", cyc - e.cyc, STG);
                        if (burst_chk && have_prev && !stalled)
                            check("burst_gap", cyc - prev_del, 1);
                        prev_del  = cyc;
                        have_prev = 1'b1;
                        stalled   = 1'b0;
                    end
                end
                if (in_valid && in_ready) begin
                    e         = model(a, b, sub);
                    e.cyc     = cyc;
                    e.chk_lat = lat_mode;
                    sb.push_back(e);
                end
                acc_hist[cyc % 8192] = in_valid && in_ready;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present one beat (or a bubble) and hold it until accepted.
    task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
        int n;
        n        = 0;
        in_valid = v;
        a        = aa;
        b        = bb;
        sub      = s;
        @(negedge clk);
        while (v && !in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_cout"}, int'(cout), 0);
        check({tag, "_ovf"}, int'(ovf), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // Directed vectors: basic add, full carry ripple, overflow, subtract.
        drive(1'b1, 16'h0001, 16'h0002, 1'b0);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        drive(1'b1, 16'h0005, 16'h0007, 1'b1);
        drive(1'b1, 16'h8000, 16'h0001, 1'b1);
        drive(1'b1, 16'h0000, 16'h0000, 1'b1);
        drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        idle(8);

        // Back-to-back burst with a four-cycle output stall.
        lat_mode  = 1'b0;
        burst_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(12);
        burst_chk = 1'b0;
        lat_mode  = 1'b1;

        // Reset with three beats in flight; nothing stale may appear later.
        for (int i = 0; i < 3; i++)
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("flush");
        idle(10);

        // Alternating bubbles must reappear unchanged four cycles later.
        bub_chk = 1'b1;
        for (int i = 0; i < 12; i++)
            drive(1'(i % 2 == 0), W'($urandom), W'($urandom), 1'($urandom));
        idle(STG + 2);
        bub_chk = 1'b0;

        // Random traffic with random backpressure.
        lat_mode = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", sb.size(), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
